// File: rtl/ccip_host_mem_responder_if.sv
// CCI-P channel 0 (read) and channel 1 (write) request/response bundle between an
// AFU memory engine (master) and the host memory responder (slave).
interface ccip_host_mem_responder_if;
  logic         c0_req_valid;
  logic [41:0]  c0_req_addr;
  logic [1:0]   c0_req_cl_len;
  logic [15:0]  c0_req_mdata;
  logic         c1_req_valid;
  logic [41:0]  c1_req_addr;
  logic [511:0] c1_req_data;
  logic [15:0]  c1_req_mdata;
  logic         c0_almost_full;
  logic         c1_almost_full;
  logic         c0_rsp_valid;
  logic [511:0] c0_rsp_data;
  logic [15:0]  c0_rsp_mdata;
  logic [1:0]   c0_rsp_cl_num;
  logic         c1_rsp_valid;
  logic [15:0]  c1_rsp_mdata;

  modport master (
    output c0_req_valid, c0_req_addr, c0_req_cl_len, c0_req_mdata,
    output c1_req_valid, c1_req_addr, c1_req_data, c1_req_mdata,
    input  c0_almost_full, c1_almost_full,
    input  c0_rsp_valid, c0_rsp_data, c0_rsp_mdata, c0_rsp_cl_num,
    input  c1_rsp_valid, c1_rsp_mdata
  );

  modport slave (
    input  c0_req_valid, c0_req_addr, c0_req_cl_len, c0_req_mdata,
    input  c1_req_valid, c1_req_addr, c1_req_data, c1_req_mdata,
    output c0_almost_full, c1_almost_full,
    output c0_rsp_valid, c0_rsp_data, c0_rsp_mdata, c0_rsp_cl_num,
    output c1_rsp_valid, c1_rsp_mdata
  );
endinterface

// File: rtl/ccip_host_mem_responder.sv
// Host-side CCI-P responder: per-channel request FIFOs feeding a burst read engine and
// a single-line write engine over one on-chip line memory, with fixed read latency.
module ccip_host_mem_responder #(
  parameter int MEM_LINES_LOG2     = 10,
  parameter int RD_LATENCY         = 8,
  parameter int REQ_FIFO_DEPTH     = 16,
  parameter int ALMOST_FULL_THRESH = 4
) (
  input  logic clk,
  input  logic reset_n,
  ccip_host_mem_responder_if.slave bus,
  output logic error
);
  localparam int IDX_W = MEM_LINES_LOG2;
  localparam int PTR_W = $clog2(REQ_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_LEVEL = CNT_W'(REQ_FIFO_DEPTH);
  localparam logic [CNT_W-1:0] AF_LEVEL   = CNT_W'(REQ_FIFO_DEPTH - ALMOST_FULL_THRESH);

  typedef logic [IDX_W-1:0] idx_t;
  typedef struct packed { idx_t idx; logic [1:0] len; logic [15:0] mdata; } rd_req_t;
  typedef struct packed { idx_t idx; logic [511:0] data; logic [15:0] mdata; } wr_req_t;
  typedef enum logic { RD_IDLE, RD_BURST } rd_state_t;

  // Upper address bits only alias onto the same line.
  logic unusedAddrBits;
  assign unusedAddrBits = ^{bus.c0_req_addr[41:IDX_W], bus.c1_req_addr[41:IDX_W]};

  // ---------------- read request FIFO ----------------
  rd_req_t          rdqStore [REQ_FIFO_DEPTH];
  rd_req_t          rdqHead;
  logic [PTR_W-1:0] rdqWrPtr, rdqRdPtr;
  logic [CNT_W-1:0] rdqCount, rdqCountNext;
  logic             rdqEmpty, rdqPush, rdqPop, rdqOverflow, rdqAlmostFull;

  assign rdqEmpty = (rdqCount == '0);
  assign rdqHead  = rdqStore[rdqRdPtr];

  // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
  always_comb begin
    rdqPush      = bus.c0_req_valid && ((rdqCount != FULL_LEVEL) || rdqPop);
    rdqOverflow  = bus.c0_req_valid && !rdqPush;
    rdqCountNext = rdqCount + CNT_W'(rdqPush) - CNT_W'(rdqPop);
  end

  always_ff @(posedge clk) begin
    if (rdqPush)
      rdqStore[rdqWrPtr] <= '{idx: bus.c0_req_addr[IDX_W-1:0], len: bus.c0_req_cl_len,
                              mdata: bus.c0_req_mdata};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdqWrPtr      <= '0;
      rdqRdPtr      <= '0;
      rdqCount      <= '0;
      rdqAlmostFull <= 1'b0;
    end else begin
      if (rdqPush) rdqWrPtr <= rdqWrPtr + 1'b1;
      if (rdqPop)  rdqRdPtr <= rdqRdPtr + 1'b1;
      rdqCount      <= rdqCountNext;
      rdqAlmostFull <= (rdqCountNext >= AF_LEVEL);
    end
  end

  // ---------------- write request FIFO ----------------
  wr_req_t          wrqStore [REQ_FIFO_DEPTH];
  wr_req_t          wrqHead;
  logic [PTR_W-1:0] wrqWrPtr, wrqRdPtr;
  logic [CNT_W-1:0] wrqCount, wrqCountNext;
  logic             wrqPush, wrqPop, wrqOverflow, wrqAlmostFull;

  assign wrqHead = wrqStore[wrqRdPtr];
  assign wrqPop  = (wrqCount != '0);

  always_comb begin
    wrqPush      = bus.c1_req_valid && ((wrqCount != FULL_LEVEL) || wrqPop);
    wrqOverflow  = bus.c1_req_valid && !wrqPush;
    wrqCountNext = wrqCount + CNT_W'(wrqPush) - CNT_W'(wrqPop);
  end

  always_ff @(posedge clk) begin
    if (wrqPush)
      wrqStore[wrqWrPtr] <= '{idx: bus.c1_req_addr[IDX_W-1:0], data: bus.c1_req_data,
                              mdata: bus.c1_req_mdata};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrqWrPtr      <= '0;
      wrqRdPtr      <= '0;
      wrqCount      <= '0;
      wrqAlmostFull <= 1'b0;
    end else begin
      if (wrqPush) wrqWrPtr <= wrqWrPtr + 1'b1;
      if (wrqPop)  wrqRdPtr <= wrqRdPtr + 1'b1;
      wrqCount      <= wrqCountNext;
      wrqAlmostFull <= (wrqCountNext >= AF_LEVEL);
    end
  end

  assign bus.c0_almost_full = rdqAlmostFull;
  assign bus.c1_almost_full = wrqAlmostFull;

  // ---------------- read engine ----------------
  rd_state_t   rdState;
  idx_t        rdBase;
  logic [1:0]  rdCnt, rdLast;
  logic [15:0] rdTag;
  logic [1:0]  headLenEff;
  logic        headBad;
  logic        ramRdEn;
  idx_t        ramRdIdx;
  logic [15:0] ramRdTag;
  logic [1:0]  ramRdCl;

  assign rdqPop = (rdState == RD_IDLE) && !rdqEmpty;

  always_comb begin
    headLenEff = (rdqHead.len == 2'd2) ? 2'd0 : rdqHead.len;
    headBad    = (rdqHead.len == 2'd2)
              || ((rdqHead.len == 2'd1) && rdqHead.idx[0])
              || ((rdqHead.len == 2'd3) && (rdqHead.idx[1:0] != 2'b00));
  end

  // The pop cycle itself reads line 0, so a burst never costs an extra cycle.
  always_comb begin
    ramRdEn  = 1'b0;
    ramRdIdx = rdBase + idx_t'(rdCnt);
    ramRdTag = rdTag;
    ramRdCl  = rdCnt;
    if (rdState == RD_BURST) begin
      ramRdEn = 1'b1;
    end else if (rdqPop) begin
      ramRdEn  = 1'b1;
      ramRdIdx = rdqHead.idx;
      ramRdTag = rdqHead.mdata;
      ramRdCl  = 2'd0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdState <= RD_IDLE;
      rdBase  <= '0;
      rdCnt   <= '0;
      rdLast  <= '0;
      rdTag   <= '0;
    end else begin
      case (rdState)
        RD_IDLE: begin
          if (rdqPop && (headLenEff != 2'd0)) begin
            rdState <= RD_BURST;
            rdBase  <= rdqHead.idx;
            rdCnt   <= 2'd1;
            rdLast  <= headLenEff;
            rdTag   <= rdqHead.mdata;
          end
        end
        RD_BURST: begin
          if (rdCnt == rdLast) rdState <= RD_IDLE;
          else                 rdCnt   <= rdCnt + 2'd1;
        end
        default: rdState <= RD_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                          error <= 1'b0;
    else if (rdqOverflow || wrqOverflow || (rdqPop && headBad)) error <= 1'b1;
  end

  // ---------------- line memory and read pipeline ----------------
  logic [511:0] mem      [1 << MEM_LINES_LOG2];
  logic [511:0] dataPipe [RD_LATENCY];
  logic         pipeValid [RD_LATENCY];
  logic [15:0]  pipeTag   [RD_LATENCY];
  logic [1:0]   pipeCl    [RD_LATENCY];

  // Non-blocking read and write in one block: a same-index read sees the old line.
  always_ff @(posedge clk) begin
    if (wrqPop)  mem[wrqHead.idx] <= wrqHead.data;
    if (ramRdEn) dataPipe[0]      <= mem[ramRdIdx];
    for (int i = 1; i < RD_LATENCY; i++) dataPipe[i] <= dataPipe[i-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RD_LATENCY; i++) begin
        pipeValid[i] <= 1'b0;
        pipeTag[i]   <= '0;
        pipeCl[i]    <= '0;
      end
    end else begin
      pipeValid[0] <= ramRdEn;
      pipeTag[0]   <= ramRdTag;
      pipeCl[0]    <= ramRdCl;
      for (int i = 1; i < RD_LATENCY; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeTag[i]   <= pipeTag[i-1];
        pipeCl[i]    <= pipeCl[i-1];
      end
    end
  end

  assign bus.c0_rsp_valid  = pipeValid[RD_LATENCY-1];
  assign bus.c0_rsp_data   = pipeValid[RD_LATENCY-1] ? dataPipe[RD_LATENCY-1] : '0;
  assign bus.c0_rsp_mdata  = pipeValid[RD_LATENCY-1] ? pipeTag[RD_LATENCY-1]  : '0;
  assign bus.c0_rsp_cl_num = pipeValid[RD_LATENCY-1] ? pipeCl[RD_LATENCY-1]   : '0;

  // ---------------- write response ----------------
  logic        c1RspValid;
  logic [15:0] c1RspMdata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c1RspValid <= 1'b0;
      c1RspMdata <= '0;
    end else begin
      c1RspValid <= wrqPop;
      c1RspMdata <= wrqPop ? wrqHead.mdata : '0;
    end
  end

  assign bus.c1_rsp_valid = c1RspValid;
  assign bus.c1_rsp_mdata = c1RspMdata;
endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Scoreboard bench for ccip_host_mem_responder: stimulus pushes expected responses with
// their due cycle; a negedge monitor pops and compares every response the DUT presents.
module tb_ccip_host_mem_responder;
  localparam int L = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic error;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  ccip_host_mem_responder_if bus ();

  ccip_host_mem_responder #(
    .MEM_LINES_LOG2(10), .RD_LATENCY(L), .REQ_FIFO_DEPTH(16), .ALMOST_FULL_THRESH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .error(error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [511:0] data; logic [15:0] mdata; logic [1:0] cl; int due; } rd_exp_t;
  typedef struct { logic [15:0] mdata; int due; } wr_exp_t;
  rd_exp_t rdQ[$];
  wr_exp_t wrQ[$];

  task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chkInt(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  function automatic logic [511:0] pat(input logic [31:0] s);
    return {16{s}};
  endfunction

  // Monitor: one line per observed response.
  always @(negedge clk) begin
    rd_exp_t re;
    wr_exp_t we;
    if (reset_n && bus.c0_rsp_valid) begin
      if (rdQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL c0_unexpected: got mdata %h cl %0d at cycle %0d expected no response",
                 bus.c0_rsp_mdata, bus.c0_rsp_cl_num, cyc);
      end else begin
        re = rdQ.pop_front();
        $display("c0 rsp cycle %0d mdata %h cl %0d data[31:0] %h",
                 cyc, bus.c0_rsp_mdata, bus.c0_rsp_cl_num, bus.c0_rsp_data[31:0]);
        chk("c0_data", bus.c0_rsp_data, re.data);
        chk("c0_mdata", 512'(bus.c0_rsp_mdata), 512'(re.mdata));
        chk("c0_cl_num", 512'(bus.c0_rsp_cl_num), 512'(re.cl));
        chkInt("c0_cycle", cyc, re.due);
      end
    end
    if (reset_n && bus.c1_rsp_valid) begin
      if (wrQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL c1_unexpected: got mdata %h at cycle %0d expected no response",
                 bus.c1_rsp_mdata, cyc);
      end else begin
        we = wrQ.pop_front();
        $display("c1 rsp cycle %0d mdata %h", cyc, bus.c1_rsp_mdata);
        chk("c1_mdata", 512'(bus.c1_rsp_mdata), 512'(we.mdata));
        chkInt("c1_cycle", cyc, we.due);
      end
    end
  end

  task automatic setRd(input logic [41:0] addr, input logic [1:0] len, input logic [15:0] tag);
    bus.c0_req_valid  = 1'b1;
    bus.c0_req_addr   = addr;
    bus.c0_req_cl_len = len;
    bus.c0_req_mdata  = tag;
  endtask

  task automatic setWr(input logic [41:0] addr, input logic [511:0] d, input logic [15:0] tag,
                       input int due);
    bus.c1_req_valid = 1'b1;
    bus.c1_req_addr  = addr;
    bus.c1_req_data  = d;
    bus.c1_req_mdata = tag;
    wrQ.push_back('{mdata: tag, due: due});
  endtask

  task automatic expRd(input logic [511:0] d, input logic [15:0] tag, input logic [1:0] cl,
                       input int due);
    rdQ.push_back('{data: d, mdata: tag, cl: cl, due: due});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    bus.c0_req_valid = 1'b0;
    bus.c1_req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic doReset();
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_c0_valid", 512'(bus.c0_rsp_valid), 512'(0));
    chk("rst_error", 512'(error), 512'(0));
    rdQ.delete();
    wrQ.delete();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [511:0] a5;
    int t0;
    a5 = {64{8'hA5}};
    bus.c0_req_valid = 1'b0; bus.c0_req_addr = '0; bus.c0_req_cl_len = '0; bus.c0_req_mdata = '0;
    bus.c1_req_valid = 1'b0; bus.c1_req_addr = '0; bus.c1_req_data = '0;   bus.c1_req_mdata = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("reset_c0_valid", 512'(bus.c0_rsp_valid), 512'(0));
    chk("reset_c1_valid", 512'(bus.c1_rsp_valid), 512'(0));
    chk("reset_error", 512'(error), 512'(0));
    chk("reset_c0_af", 512'(bus.c0_almost_full), 512'(0));
    chk("reset_c1_af", 512'(bus.c1_almost_full), 512'(0));
    chk("reset_c0_data", bus.c0_rsp_data, 512'(0));
    chk("reset_c0_mdata", 512'(bus.c0_rsp_mdata), 512'(0));
    chk("reset_c0_cl", 512'(bus.c0_rsp_cl_num), 512'(0));
    chk("reset_c1_mdata", 512'(bus.c1_rsp_mdata), 512'(0));
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Write then read one line
    setWr(42'h10, a5, 16'h0001, cyc + 2); step(); idle(3);
    expRd(a5, 16'h0002, 2'd0, cyc + 1 + L);
    setRd(42'h10, 2'd0, 16'h0002); step(); idle(L + 4);

    // Fill lines used by later bursts, then an aligned 4-line burst
    for (int i = 0; i < 4; i++) begin
      setWr(42'h20 + 42'(i), pat(32'h2000 + 32'(i)), 16'h0010 + 16'(i), cyc + 2); step();
    end
    setWr(42'h24,  pat(32'h2004), 16'h0014, cyc + 2); step();
    setWr(42'h3FF, pat(32'h3FF0), 16'h0015, cyc + 2); step();
    setWr(42'h0,   pat(32'h0F0F), 16'h0016, cyc + 2); step();
    idle(3);
    for (int k = 0; k < 4; k++) expRd(pat(32'h2000 + 32'(k)), 16'h0003, 2'(k), cyc + 1 + L + k);
    setRd(42'h20, 2'd3, 16'h0003); step(); idle(L + 6);
    chk("burst4_error", 512'(error), 512'(0));

    // Misaligned 2-line burst is served unaligned
    expRd(pat(32'h2001), 16'h0004, 2'd0, cyc + 1 + L);
    expRd(pat(32'h2002), 16'h0004, 2'd1, cyc + 2 + L);
    setRd(42'h21, 2'd1, 16'h0004); step(); idle(L + 4);
    chk("misalign_error", 512'(error), 512'(1));
    doReset();

    // Illegal cl_len 2 yields a single line
    expRd(pat(32'h2002), 16'h0005, 2'd0, cyc + 1 + L);
    setRd(42'h22, 2'd2, 16'h0005); step(); idle(L + 4);
    chk("len2_error", 512'(error), 512'(1));
    doReset();

    // Misaligned burst wrapping past the top of memory
    expRd(pat(32'h3FF0), 16'h0006, 2'd0, cyc + 1 + L);
    expRd(pat(32'h0F0F), 16'h0006, 2'd1, cyc + 2 + L);
    setRd(42'h3FF, 2'd1, 16'h0006); step(); idle(L + 4);
    chk("wrap_error", 512'(error), 512'(1));
    doReset();

    // Same-cycle write (aliased address 0x405) and read of index 5
    setWr(42'h5, pat(32'h5555), 16'h0007, cyc + 2); step(); idle(3);
    setWr(42'h405, pat(32'hBEEF), 16'h0008, cyc + 2);
    expRd(pat(32'h5555), 16'h0009, 2'd0, cyc + 1 + L);
    setRd(42'h5, 2'd0, 16'h0009); step(); idle(L + 4);
    expRd(pat(32'hBEEF), 16'h000A, 2'd0, cyc + 1 + L);
    setRd(42'h5, 2'd0, 16'h000A); step(); idle(L + 4);
    chk("rbw_error", 512'(error), 512'(0));

    // Overflow: 4-line bursts drain one pop per 4 cycles; request 21 meets a full FIFO
    // with a pop (accepted), request 22 meets it without one (dropped).
    t0 = cyc;
    for (int i = 0; i < 23; i++) begin
      if (i == 15) chk("af_before", 512'(bus.c0_almost_full), 512'(0));
      if (i == 16) chk("af_after", 512'(bus.c0_almost_full), 512'(1));
      if (i == 22) chk("ovf_error_before", 512'(error), 512'(0));
      if (i < 22)
        for (int k = 0; k < 4; k++)
          expRd(pat(32'h2000 + 32'(k)), 16'h0100 + 16'(i), 2'(k), t0 + 1 + 4 * i + k + L);
      setRd(42'h20, 2'd3, 16'h0100 + 16'(i)); step();
    end
    chk("ovf_error_after", 512'(error), 512'(1));
    idle(100);
    chk("af_drained", 512'(bus.c0_almost_full), 512'(0));
    chkInt("ovf_all_returned", rdQ.size(), 0);
    doReset();

    // Reset in the middle of a burst
    t0 = cyc;
    for (int k = 0; k < 4; k++) expRd(pat(32'h2001 + 32'(k)), 16'h0020, 2'(k), t0 + 1 + L + k);
    setRd(42'h21, 2'd3, 16'h0020); step();
    while (cyc < t0 + L + 2) begin @(posedge clk); #1; end
    chk("midburst_valid", 512'(bus.c0_rsp_valid), 512'(1));
    chk("midburst_error", 512'(error), 512'(1));
    #1 reset_n = 1'b0;
    #1;
    chk("async_rst_valid", 512'(bus.c0_rsp_valid), 512'(0));
    chk("async_rst_data", bus.c0_rsp_data, 512'(0));
    chk("async_rst_error", 512'(error), 512'(0));
    rdQ.delete();
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    @(posedge clk);
    #1;
    idle(30);
    expRd(a5, 16'h0030, 2'd0, cyc + 1 + L);
    setRd(42'h10, 2'd0, 16'h0030); step(); idle(L + 4);

    chkInt("rdq_empty", rdQ.size(), 0);
    chkInt("wrq_empty", wrQ.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
